// File: rtl/sqrt_pkg.sv
// Shared definitions for the sequential squarer and its companion sqrt block.
// N is always the wide side: the square / radicand width. The operand / root is N/2.
package sqrt_pkg;

    // Control states used by the iterative datapath.
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } sq_state_t;

    // Default wide-side width, and the matching narrow (operand / root) width.
    localparam int SQ_N_DEFAULT    = 32;
    localparam int SQ_OP_W_DEFAULT = SQ_N_DEFAULT / 2;

    // Counter width able to hold the iteration count N/2.
    function automatic int sq_cnt_width(input int n);
        return $clog2(n / 2 + 1);
    endfunction

endpackage

// File: rtl/seq_square_if.sv
// Start/done handshake bundle for seq_square.
// The master drives the request side and the slave returns the result.
interface seq_square_if
    import sqrt_pkg::*;
#(
    parameter int N = SQ_N_DEFAULT
);

    logic             start;
    logic [N/2-1:0]   num_in;
    logic [N-1:0]     sq_out;
    logic             busy;
    logic             done;

    modport master (
        output start,
        output num_in,
        input  sq_out,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  num_in,
        output sq_out,
        output busy,
        output done
    );

endinterface

// File: rtl/seq_square.sv
// Iterative shift-add squarer: N/2-bit unsigned operand in, N-bit square out.
// Fixed latency of N/2 iterations after the start edge, with no early exit.
module seq_square
    import sqrt_pkg::*;
#(
    parameter int N = SQ_N_DEFAULT
) (
    input  logic          Clock,
    input  logic          reset,
    seq_square_if.slave   bus
);

    localparam int HALF = N / 2;
    localparam int CW   = sq_cnt_width(N);

    // Reject odd or too-narrow widths when the design is elaborated.
    generate
        if (((N % 2) != 0) || (N < 4)) begin : g_param_check
            $error("seq_square: N must be even and >= 4");
        end
    endgenerate

    sq_state_t         state_q,  state_d;
    logic [N-1:0]      acc_q,    acc_d;
    logic [N-1:0]      mcand_q,  mcand_d;
    logic [HALF-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]     cnt_q,    cnt_d;
    logic [N-1:0]      sq_out_q, sq_out_d;
    logic [N-1:0]      addend;

    // Next-state and datapath update: load on an accepted start, then one
    // shift-add step per cycle until the last iteration publishes the result.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        sq_out_d = sq_out_q;
        addend   = mplier_q[0] ? mcand_q : '0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    mplier_d = bus.num_in;
                    mcand_d  = {{HALF{1'b0}}, bus.num_in};
                    acc_d    = '0;
                    cnt_d    = CW'(HALF);
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                acc_d    = acc_q + addend;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    sq_out_d = acc_q + addend;
                    state_d  = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; synchronous reset clears everything and
    // aborts any operation in flight.
    always_ff @(posedge Clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            sq_out_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            sq_out_q <= sq_out_d;
        end
    end

    // Status flags are pure decodes of the registered state, so they can never
    // both be high and both are low only in IDLE.
    assign bus.busy   = (state_q == S_RUN);
    assign bus.done   = (state_q == S_DONE);
    assign bus.sq_out = sq_out_q;

endmodule
